// File: rtl/hash_bits_off_pkg.sv
// Shared definitions for the bits-off pipeline: count width, the largest
// legal bits-off value and the report FSM state encoding.
package hash_bits_off_pkg;

  localparam int BITS_OFF_WIDTH = 11;
  localparam int MAX_BITS_OFF   = 1024;

  typedef enum logic {
    R_IDLE    = 1'b0,
    R_PENDING = 1'b1
  } report_state_t;

endpackage

// File: rtl/hash_bits_off_best_tracker.sv
// Tracks the lowest bits-off count since reset, counts evaluated hashes and
// offers each new best to the reporting path over valid/ready. While a
// report is pending its data is frozen; only the latest best is reported.
module hash_bits_off_best_tracker
  import hash_bits_off_pkg::*;
#(
  parameter int CANDIDATE_WIDTH = 128,
  parameter int BITS_OFF_WIDTH  = hash_bits_off_pkg::BITS_OFF_WIDTH,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       done_i,
  input  logic [BITS_OFF_WIDTH-1:0]  bits_off_i,
  input  logic [CANDIDATE_WIDTH-1:0] candidate_i,
  output logic                       best_valid_o,
  output logic [BITS_OFF_WIDTH-1:0]  best_bits_off_o,
  output logic [CANDIDATE_WIDTH-1:0] best_candidate_o,
  output logic                       new_best_o,
  output logic [COUNT_WIDTH-1:0]     hash_count_o,
  output logic                       report_valid_o,
  input  logic                       report_ready_i,
  output logic [BITS_OFF_WIDTH-1:0]  report_bits_off_o,
  output logic [CANDIDATE_WIDTH-1:0] report_candidate_o
);

  logic                       r_best_valid;
  logic [BITS_OFF_WIDTH-1:0]  r_best_bits_off;
  logic [CANDIDATE_WIDTH-1:0] r_best_candidate;
  logic                       r_new_best;
  logic [COUNT_WIDTH-1:0]     r_hash_count;
  logic [BITS_OFF_WIDTH-1:0]  r_report_bits_off;
  logic [CANDIDATE_WIDTH-1:0] r_report_candidate;
  logic                       r_dirty;
  report_state_t              r_state;
  report_state_t              w_state_next;

  logic                       w_improve;
  logic [BITS_OFF_WIDTH-1:0]  w_next_bits_off;
  logic [CANDIDATE_WIDTH-1:0] w_next_candidate;

  // Strict less-than so a tie keeps the earlier result
  assign w_improve        = done_i && (!r_best_valid || (bits_off_i < r_best_bits_off));
  // Best value as it will stand after this edge, used to refresh a snapshot
  assign w_next_bits_off  = w_improve ? bits_off_i  : r_best_bits_off;
  assign w_next_candidate = w_improve ? candidate_i : r_best_candidate;

  // Best registers, new-best pulse and saturating hash counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_best_valid     <= 1'b0;
      r_best_bits_off  <= '1;
      r_best_candidate <= '0;
      r_new_best       <= 1'b0;
      r_hash_count     <= '0;
    end else begin
      r_new_best <= w_improve;
      if (w_improve) begin
        r_best_valid     <= 1'b1;
        r_best_bits_off  <= bits_off_i;
        r_best_candidate <= candidate_i;
      end
      if (done_i && (r_hash_count != '1)) begin
        r_hash_count <= r_hash_count + COUNT_WIDTH'(1);
      end
    end
  end

  // Report FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Report FSM next state: leave PENDING only when the accepted report is the latest best
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      R_IDLE: begin
        if (w_improve) begin
          w_state_next = R_PENDING;
        end
      end
      R_PENDING: begin
        if (report_ready_i && !r_dirty && !w_improve) begin
          w_state_next = R_IDLE;
        end
      end
      default: w_state_next = R_IDLE;
    endcase
  end

  // Report snapshot and dirty flag; snapshot only moves when no report is outstanding
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_report_bits_off  <= '1;
      r_report_candidate <= '0;
      r_dirty            <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          r_dirty <= 1'b0;
          if (w_improve) begin
            r_report_bits_off  <= bits_off_i;
            r_report_candidate <= candidate_i;
          end
        end
        R_PENDING: begin
          if (report_ready_i) begin
            r_dirty <= 1'b0;
            if (r_dirty || w_improve) begin
              r_report_bits_off  <= w_next_bits_off;
              r_report_candidate <= w_next_candidate;
            end
          end else if (w_improve) begin
            r_dirty <= 1'b1;
          end
        end
        default: r_dirty <= 1'b0;
      endcase
    end
  end

  // Report FSM outputs
  always_comb begin
    report_valid_o = (r_state == R_PENDING);
  end

  assign best_valid_o       = r_best_valid;
  assign best_bits_off_o    = r_best_bits_off;
  assign best_candidate_o   = r_best_candidate;
  assign new_best_o         = r_new_best;
  assign hash_count_o       = r_hash_count;
  assign report_bits_off_o  = r_report_bits_off;
  assign report_candidate_o = r_report_candidate;

endmodule

// File: tb/tb_hash_bits_off_best_tracker.sv
// Bench for hash_bits_off_best_tracker: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of "lowest result so far, report the latest best".
module tb_hash_bits_off_best_tracker;

  localparam int CW = 128;
  localparam int BW = 11;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          done_i = 1'b0;
  logic [BW-1:0] bits_off_i = '0;
  logic [CW-1:0] candidate_i = '0;
  logic          report_ready_i = 1'b0;

  logic          best_valid_o, new_best_o, report_valid_o;
  logic [BW-1:0] best_bits_off_o, report_bits_off_o;
  logic [CW-1:0] best_candidate_o, report_candidate_o;
  logic [31:0]   hash_count_o;

  logic          s_best_valid, s_new_best, s_report_valid;
  logic [BW-1:0] s_best_bits, s_report_bits;
  logic [CW-1:0] s_best_cand, s_report_cand;
  logic [3:0]    s_hash_count;

  always #5 clk = ~clk;

  hash_bits_off_best_tracker u_dut (
    .clk_i(clk), .rst_i(rst_i), .done_i(done_i), .bits_off_i(bits_off_i),
    .candidate_i(candidate_i), .best_valid_o(best_valid_o),
    .best_bits_off_o(best_bits_off_o), .best_candidate_o(best_candidate_o),
    .new_best_o(new_best_o), .hash_count_o(hash_count_o),
    .report_valid_o(report_valid_o), .report_ready_i(report_ready_i),
    .report_bits_off_o(report_bits_off_o), .report_candidate_o(report_candidate_o)
  );

  hash_bits_off_best_tracker #(.COUNT_WIDTH(4)) u_small (
    .clk_i(clk), .rst_i(rst_i), .done_i(done_i), .bits_off_i(bits_off_i),
    .candidate_i(candidate_i), .best_valid_o(s_best_valid),
    .best_bits_off_o(s_best_bits), .best_candidate_o(s_best_cand),
    .new_best_o(s_new_best), .hash_count_o(s_hash_count),
    .report_valid_o(s_report_valid), .report_ready_i(report_ready_i),
    .report_bits_off_o(s_report_bits), .report_candidate_o(s_report_cand)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  bit          m_valid = 0;
  int          m_best = 2047;
  logic [CW-1:0] m_cand = '0;
  bit          m_new = 0;
  longint      m_count = 0;
  int          m_count_s = 0;
  bit          m_rvalid = 0;
  int          m_rbits = 2047;
  logic [CW-1:0] m_rcand = '0;
  int          dut_xfers = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: lowest result wins; a pending report is replaced on acceptance
  // by the current best if the best moved since the report was taken.
  always @(posedge clk) begin
    bit imp;
    if (rst_i) begin
      m_valid = 0; m_best = 2047; m_cand = '0; m_new = 0; m_count = 0;
      m_count_s = 0; m_rvalid = 0; m_rbits = 2047; m_rcand = '0;
    end else begin
      if (report_valid_o && report_ready_i) dut_xfers++;
      imp = done_i && (!m_valid || int'(bits_off_i) < m_best);
      m_new = imp;
      if (done_i) begin
        if (m_count < 64'hFFFF_FFFF) m_count++;
        if (m_count_s < 15) m_count_s++;
      end
      if (imp) begin
        m_valid = 1; m_best = int'(bits_off_i); m_cand = candidate_i;
      end
      if (!m_rvalid) begin
        if (imp) begin
          m_rvalid = 1; m_rbits = m_best; m_rcand = m_cand;
        end
      end else if (report_ready_i) begin
        if (m_rbits != m_best) begin
          m_rbits = m_best; m_rcand = m_cand;
        end else begin
          m_rvalid = 0;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    check("best_valid", CW'(best_valid_o), CW'(m_valid));
    check("best_bits", CW'(best_bits_off_o), CW'(m_best));
    check("best_cand", best_candidate_o, m_cand);
    check("new_best", CW'(new_best_o), CW'(m_new));
    check("hash_count", CW'(hash_count_o), CW'(m_count));
    check("hash_count_w4", CW'(s_hash_count), CW'(m_count_s));
    check("report_valid", CW'(report_valid_o), CW'(m_rvalid));
    if (m_rvalid) begin
      check("report_bits", CW'(report_bits_off_o), CW'(m_rbits));
      check("report_cand", report_candidate_o, m_rcand);
    end
  end

  task automatic tick(input bit d, input int b, input logic [CW-1:0] c, input bit r);
    done_i = d; bits_off_i = BW'(b); candidate_i = c; report_ready_i = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(0, 0, '0, 0);
    rst_i = 1'b0;
  endtask

  localparam logic [CW-1:0] CAND_A = 128'hAAAA_0001;
  localparam logic [CW-1:0] CAND_B = 128'hBBBB_0002;
  localparam logic [CW-1:0] CAND_C = 128'hCCCC_0003;

  initial begin
    int x0;
    @(negedge clk);
    do_reset();
    check("reset_report_bits", CW'(report_bits_off_o), CW'(2047));

    // First result becomes best and is offered one edge later
    tick(1, 500, CAND_A, 0);
    check("t1_best", CW'(best_bits_off_o), CW'(500));
    check("t1_cand", best_candidate_o, CAND_A);
    check("t1_newbest", CW'(new_best_o), CW'(1));
    check("t1_rvalid", CW'(report_valid_o), CW'(1));
    check("t1_rbits", CW'(report_bits_off_o), CW'(500));
    tick(0, 0, '0, 0);
    check("t1_newbest_drop", CW'(new_best_o), CW'(0));
    tick(0, 0, '0, 1);
    check("t1_idle", CW'(report_valid_o), CW'(0));

    // 500,600,500,420 with ready held: two transfers, count 4
    do_reset();
    x0 = dut_xfers;
    tick(1, 500, CAND_A, 1);
    tick(1, 600, CAND_B, 1);
    tick(1, 500, CAND_C, 1);
    tick(1, 420, CAND_B, 1);
    tick(0, 0, '0, 1);
    tick(0, 0, '0, 1);
    check("t2_best", CW'(best_bits_off_o), CW'(420));
    check("t2_cand", best_candidate_o, CAND_B);
    check("t2_count", CW'(hash_count_o), CW'(4));
    check("t2_xfers", CW'(dut_xfers - x0), CW'(2));

    // Held report while busy, then refresh on acceptance
    do_reset();
    tick(1, 500, CAND_A, 0);
    tick(1, 430, CAND_B, 0);
    check("t3_held_bits", CW'(report_bits_off_o), CW'(500));
    check("t3_held_cand", report_candidate_o, CAND_A);
    check("t3_best", CW'(best_bits_off_o), CW'(430));
    tick(0, 0, '0, 1);
    check("t3_refresh_valid", CW'(report_valid_o), CW'(1));
    check("t3_refresh_bits", CW'(report_bits_off_o), CW'(430));
    // Improvement in the same cycle 430 is accepted
    tick(1, 300, CAND_C, 1);
    check("t4_valid", CW'(report_valid_o), CW'(1));
    check("t4_bits", CW'(report_bits_off_o), CW'(300));
    check("t4_cand", report_candidate_o, CAND_C);
    tick(0, 0, '0, 1);
    check("t4_idle", CW'(report_valid_o), CW'(0));

    // Zero is a legal best; a tie does not improve
    tick(1, 0, CAND_A, 0);
    tick(1, 0, CAND_B, 0);
    check("t5_zero", CW'(best_bits_off_o), CW'(0));
    check("t5_tie_cand", best_candidate_o, CAND_A);
    check("t5_tie_nopulse", CW'(new_best_o), CW'(0));

    // Saturation of a 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) tick(1, 700 - i, CW'(i), 1);
    tick(0, 0, '0, 1);
    check("t6_sat", CW'(s_hash_count), CW'(15));
    check("t6_wide", CW'(hash_count_o), CW'(20));

    // Reset while a report is pending
    tick(1, 5, CAND_A, 0);
    check("t7_pending", CW'(report_valid_o), CW'(1));
    do_reset();
    check("t7_rvalid", CW'(report_valid_o), CW'(0));
    check("t7_bvalid", CW'(best_valid_o), CW'(0));
    check("t7_bits", CW'(best_bits_off_o), CW'(2047));
    check("t7_count", CW'(hash_count_o), CW'(0));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int b;
      rst_i = ($urandom_range(0, 199) == 0);
      b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 1024));
      tick(bit'($urandom_range(0, 1)), b, {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 9) < 4));
    end
    rst_i = 1'b0;
    tick(0, 0, '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hash_bits_off_best_tracker.md
# hash_bits_off_best_tracker

Downstream consumer of the bits-off stage: samples each completed bits-off count together with the candidate that produced it. Keeps the lowest count seen since reset, counts evaluated hashes, and offers each new best to the reporting path (UART formatter) over a valid/ready handshake. A report stays stable while the reporting path is busy.

## Interface
- CANDIDATE_WIDTH, 128, width of the candidate (input string / nonce) that was hashed
- BITS_OFF_WIDTH, 11, width of a bits-off count (0..1024)
- COUNT_WIDTH, 32, width of the evaluated-hash counter

Ports:
- clk_i  in  1  the single clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- done_i  in  1  one-cycle pulse from the bits-off stage: count is final
- bits_off_i  in  BITS_OFF_WIDTH  bits-off count, valid when done_i=1
- candidate_i  in  CANDIDATE_WIDTH  candidate belonging to that count, valid when done_i=1
- best_valid_o  out  1  at least one result recorded since reset
- best_bits_off_o  out  BITS_OFF_WIDTH  lowest count so far
- best_candidate_o  out  CANDIDATE_WIDTH  candidate that produced best_bits_off_o
- new_best_o  out  1  one-cycle pulse, best registers changed on this edge
- hash_count_o  out  COUNT_WIDTH  number of done_i pulses, saturating
- report_valid_o  out  1  report available
- report_ready_i  in  1  reporting path accepts report this cycle
- report_bits_off_o  out  BITS_OFF_WIDTH  report snapshot count
- report_candidate_o  out  CANDIDATE_WIDTH  report snapshot candidate

## Operation
- Improvement when done_i=1 and (best_valid_o=0 or bits_off_i < best_bits_off_o); strict less-than, ties keep earlier result.
- On improvement: best_bits_off_o<=bits_off_i, best_candidate_o<=candidate_i, best_valid_o<=1, new_best_o<=1 for one cycle.
- hash_count_o increments on every done_i; holds at all-ones.
- Report FSM, two states:
  - R_IDLE: report_valid_o=0. On improvement: snapshot<=new best, go R_PENDING.
  - R_PENDING: report_valid_o=1, snapshot frozen. Improvement without acceptance sets dirty flag, and best updates normally.
  - R_PENDING with report_ready_i=1 and (dirty or improvement this cycle): snapshot<=next best value (including this cycle's improvement), dirty<=0, stay R_PENDING. The following cycle is a new transfer.
  - R_PENDING with report_ready_i=1 and neither condition: go R_IDLE, dirty<=0.
- Only the latest best is ever reported; intermediate bests lost while pending are intentional.
- report_ready_i is ignored in R_IDLE.

## Timing
- Reset values: best_valid_o=0, best_bits_off_o=all ones, best_candidate_o=0, new_best_o=0, hash_count_o=0, report_valid_o=0, report_bits_off_o=all ones, report_candidate_o=0, dirty=0, state R_IDLE.
- rst_i wins over everything. Reset during R_PENDING drops the report.
- done_i at edge N: best/count/new_best_o visible after edge N; report_valid_o high after edge N if in R_IDLE (1-cycle latency).
- done_i may pulse every cycle. No back-pressure toward the bits-off stage, and every pulse is counted.
- Handshake: transfer on report_valid_o && report_ready_i at an edge. Report data must not change while report_valid_o=1 and no transfer has occurred.
- bits_off_i=0 is a legal best; later 0 results do not improve it.

## Structure
- Shared package hash_bits_off_pkg: BITS_OFF_WIDTH=11, MAX_BITS_OFF=1024, report state encoding (R_IDLE=0, R_PENDING=1). The bits-off stage and the UART formatter import it too.
- Single module, no sub-module. The saturating counter and the comparator stay inline.

## Test plan
- Reset, then done_i with bits_off_i=500, cand=A → best_valid_o=1, best=500/A, new_best_o one pulse, report_valid_o=1 with 500/A after one edge.
- Sequence 500,600,500,420 with ready held 1 → bests 500 then 420, exactly two report transfers, hash_count_o=4.
- ready held 0, results 500 then 430 → report stays 500/A; best becomes 430. Ready pulse → 500 transferred, report_valid_o stays 1 with 430 next cycle. Second ready → R_IDLE.
- Improvement to 300 in the same cycle ready accepts 430 → next report is 300, valid uninterrupted.
- hash_count_o preset near saturation (COUNT_WIDTH=4 build) with 20 done_i pulses → holds 15.
- rst_i asserted while R_PENDING → next cycle report_valid_o=0, best_valid_o=0, best_bits_off_o=2047, count=0.
